// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register with next-PC selection (sequential, redirect, trap on misaligned target).
// Optional taken-redirect counter enabled by defining REDIRECT_CNT_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        InstrReady,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        TrapAck,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        PCValidF,
    output logic        MisalignF,
    output logic [31:0] BadAddrF,
    output logic [31:0] RedirectCnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic        advance;
    logic        target_misaligned;

    assign advance           = InstrReady & ~StallF;
    assign target_misaligned = (PCTargetE[1:0] != 2'b00);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (PCSrcE && target_misaligned) begin
                    state_d = S_TRAP;
                end
            end
            S_TRAP: begin
                if (TrapAck) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        PCValidF  = (state_q == S_RUN);
        MisalignF = (state_q == S_TRAP);
    end

    // Redirect beats stall: a taken branch must land even if fetch is frozen.
    always_comb begin
        pcf_d      = pcf_q;
        bad_addr_d = bad_addr_q;
        if (state_q == S_RUN) begin
            if (PCSrcE) begin
                if (target_misaligned) begin
                    pcf_d      = TRAP_VEC;
                    bad_addr_d = PCTargetE;
                end else begin
                    pcf_d = PCTargetE;
                end
            end else if (advance) begin
                pcf_d = pcplus4_q;
            end
        end
        pcplus4_d = pcf_d + 32'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcf_q      <= RESET_VEC;
            pcplus4_q  <= RESET_VEC + 32'd4;
            bad_addr_q <= 32'h0;
        end else begin
            pcf_q      <= pcf_d;
            pcplus4_q  <= pcplus4_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign PCF      = pcf_q;
    assign PCPlus4F = pcplus4_q;
    assign BadAddrF = bad_addr_q;

`ifdef REDIRECT_CNT_EN
    logic        redirect_take;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    assign redirect_take = (state_q == S_RUN) && PCSrcE && !target_misaligned;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redirect_take && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_cnt_q <= 32'h0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign RedirectCnt = redirect_cnt_q;
`else
    assign RedirectCnt = 32'h0;
`endif

    a_plus4_tracks_pcf: assert property (@(posedge clk) disable iff (!rst)
        PCPlus4F == PCF + 32'd4);
    a_trap_not_valid: assert property (@(posedge clk) disable iff (!rst)
        !(MisalignF && PCValidF));

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: cycle table through fetch, redirect, trap
// and wrap, plus hand sequences for BOOT behaviour and asynchronous reset.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        InstrReady;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        TrapAck;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        PCValidF;
    logic        MisalignF;
    logic [31:0] BadAddrF;
    logic [31:0] RedirectCnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REDIRECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    pc_redirect_unit dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .InstrReady (InstrReady),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .TrapAck    (TrapAck),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .PCValidF   (PCValidF),
        .MisalignF  (MisalignF),
        .BadAddrF   (BadAddrF),
        .RedirectCnt(RedirectCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        src;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] exp_pcf;
        logic [31:0] exp_p4;
        logic        exp_valid;
        logic        exp_mis;
        logic [31:0] exp_bad;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " PCF"},         PCF,               32'h0);
        check({tag, " PCPlus4F"},    PCPlus4F,          32'h4);
        check({tag, " PCValidF"},    {31'b0, PCValidF}, 32'h0);
        check({tag, " MisalignF"},   {31'b0, MisalignF},32'h0);
        check({tag, " BadAddrF"},    BadAddrF,          32'h0);
        check({tag, " RedirectCnt"}, RedirectCnt,       32'h0);
    endtask

    task automatic set_row(input int i, input logic st, input logic rd, input logic sr,
                           input logic [31:0] tg, input logic ak, input logic [31:0] pcf,
                           input logic vl, input logic ms, input logic [31:0] bad,
                           input logic [31:0] cnt);
        vecs[i].stall     = st;
        vecs[i].ready     = rd;
        vecs[i].src       = sr;
        vecs[i].tgt       = tg;
        vecs[i].ack       = ak;
        vecs[i].exp_pcf   = pcf;
        vecs[i].exp_p4    = pcf + 32'd4;
        vecs[i].exp_valid = vl;
        vecs[i].exp_mis   = ms;
        vecs[i].exp_bad   = bad;
        vecs[i].exp_cnt   = CNT_EN ? cnt : 32'h0;
    endtask

    initial begin
        //          st rd sr tgt            ak  PCF            vl ms bad    cnt
        set_row( 0, 0, 1, 0, 32'h0,        0, 32'h0000_0000, 1, 0, 32'h0,  0); // BOOT -> RUN, held
        set_row( 1, 0, 1, 0, 32'h0,        0, 32'h0000_0004, 1, 0, 32'h0,  0);
        set_row( 2, 0, 1, 0, 32'h0,        0, 32'h0000_0008, 1, 0, 32'h0,  0);
        set_row( 3, 0, 1, 0, 32'h0,        0, 32'h0000_000C, 1, 0, 32'h0,  0);
        set_row( 4, 0, 1, 0, 32'h0,        0, 32'h0000_0010, 1, 0, 32'h0,  0);
        set_row( 5, 1, 1, 1, 32'h40,       0, 32'h0000_0040, 1, 0, 32'h0,  1); // redirect over stall
        set_row( 6, 1, 1, 0, 32'h0,        0, 32'h0000_0040, 1, 0, 32'h0,  1);
        set_row( 7, 0, 0, 0, 32'h0,        0, 32'h0000_0040, 1, 0, 32'h0,  1); // imem not ready
        set_row( 8, 0, 1, 0, 32'h0,        0, 32'h0000_0044, 1, 0, 32'h0,  1);
        set_row( 9, 0, 1, 1, 32'h42,       0, 32'h0000_0100, 0, 1, 32'h42, 1); // misaligned -> trap
        set_row(10, 0, 1, 1, 32'h80,       0, 32'h0000_0100, 0, 1, 32'h42, 1); // redirect ignored in trap
        set_row(11, 0, 1, 0, 32'h0,        1, 32'h0000_0100, 1, 0, 32'h42, 1); // ack -> RUN
        set_row(12, 0, 1, 0, 32'h0,        0, 32'h0000_0104, 1, 0, 32'h42, 1);
        set_row(13, 0, 1, 0, 32'h0,        1, 32'h0000_0108, 1, 0, 32'h42, 1); // ack outside trap
        set_row(14, 0, 1, 1, 32'hFFFF_FFFC,0, 32'hFFFF_FFFC, 1, 0, 32'h42, 2);
        set_row(15, 0, 1, 0, 32'h0,        0, 32'h0000_0000, 1, 0, 32'h42, 2); // wrap
        set_row(16, 1, 1, 0, 32'h0,        0, 32'h0000_0000, 1, 0, 32'h42, 2);
        set_row(17, 1, 1, 0, 32'h0,        0, 32'h0000_0000, 1, 0, 32'h42, 2);
        set_row(18, 1, 1, 0, 32'h0,        0, 32'h0000_0000, 1, 0, 32'h42, 2);
        set_row(19, 0, 1, 1, 32'h3,        0, 32'h0000_0100, 0, 1, 32'h3,  2); // second trap
        set_row(20, 0, 1, 0, 32'h0,        1, 32'h0000_0100, 1, 0, 32'h3,  2);
        set_row(21, 0, 1, 1, 32'h200,      0, 32'h0000_0200, 1, 0, 32'h3,  3);

        rst        = 1'b0;
        StallF     = 1'b0;
        InstrReady = 1'b1;
        PCSrcE     = 1'b0;
        PCTargetE  = 32'h0;
        TrapAck    = 1'b0;

        #12;
        check_reset_values("reset");
        rst = 1'b1;
        #1;
        check("boot PCValidF", {31'b0, PCValidF}, 32'h0);

        for (int i = 0; i < 22; i++) begin
            StallF     = vecs[i].stall;
            InstrReady = vecs[i].ready;
            PCSrcE     = vecs[i].src;
            PCTargetE  = vecs[i].tgt;
            TrapAck    = vecs[i].ack;
            @(posedge clk);
            #1;
            check($sformatf("row%0d PCF", i),       PCF,                vecs[i].exp_pcf);
            check($sformatf("row%0d PCPlus4F", i),  PCPlus4F,           vecs[i].exp_p4);
            check($sformatf("row%0d PCValidF", i),  {31'b0, PCValidF},  {31'b0, vecs[i].exp_valid});
            check($sformatf("row%0d MisalignF", i), {31'b0, MisalignF}, {31'b0, vecs[i].exp_mis});
            check($sformatf("row%0d BadAddrF", i),  BadAddrF,           vecs[i].exp_bad);
            check($sformatf("row%0d RedirectCnt", i), RedirectCnt,      vecs[i].exp_cnt);
        end

        // Enter trap, then pull reset mid-cycle: outputs must drop at once.
        PCSrcE    = 1'b1;
        PCTargetE = 32'h6;
        StallF    = 1'b0;
        TrapAck   = 1'b0;
        @(posedge clk);
        #1;
        check("pre-reset trap MisalignF", {31'b0, MisalignF}, 32'h1);
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("async mid-trap");

        // Release with a redirect pending: BOOT must ignore it, RUN must take it.
        PCSrcE    = 1'b1;
        PCTargetE = 32'h80;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("boot ignores redirect PCF", PCF,                32'h0);
        check("boot exit PCValidF",        {31'b0, PCValidF},  32'h1);
        @(posedge clk);
        #1;
        check("post-boot redirect PCF",    PCF,                32'h80);
        PCSrcE = 1'b0;
        StallF = 1'b1;
        @(posedge clk);
        #1;
        check("stall hold PCF",            PCF,                32'h80);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async mid-stall");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
